// File: rtl/pdp8_dma_arb.sv
// Round-robin arbiter for the pdp8 external-RAM (DMA) port.
// Sequences one RAM read/write per grant and pulses done/err back to the winner.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req_rd/req_wr       per-requester level requests (NREQ bits)
//   req_ma/req_wdata    per-requester address (15b) / write data (12b) slices
//   req_done/req_err    one-cycle completion pulse to winner / timeout flag
//   req_rdata           read data, valid while req_done is high
//   ram_read_req/ram_write_req/ram_ma/ram_out   drive CPU ext_ram_* inputs
//   ram_in/ram_done     CPU ext_ram_out data and completion
module pdp8_dma_arb #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [15*NREQ-1:0]   req_ma,
    input  logic [12*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic [11:0]          req_rdata,
    output logic                 ram_read_req,
    output logic                 ram_write_req,
    output logic [14:0]          ram_ma,
    output logic [11:0]          ram_out,
    input  logic [11:0]          ram_in,
    input  logic                 ram_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   rr_ptr, rr_n;
    logic [PW-1:0]   win, win_n;
    logic [7:0]      cnt, cnt_n;

    logic [NREQ-1:0] done_n;
    logic            err_n;
    logic [11:0]     rdata_n;
    logic            rd_req_n, wr_req_n;
    logic [14:0]     ma_n;
    logic [11:0]     out_n;

    logic [NREQ-1:0] active;
    logic            found;
    logic [PW-1:0]   pick, idx;
    int              s;
    logic            pick_wr;
    logic [14:0]     pick_ma;
    logic [11:0]     pick_wd;

    // Search from rr_ptr upward, wrapping explicitly at NREQ.
    always_comb begin
        active  = req_rd | req_wr;
        found   = 1'b0;
        pick    = '0;
        idx     = '0;
        s       = 0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            idx = PW'(s);
            if (!found && active[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_wr = req_wr[pick];
        pick_ma = req_ma[15*pick +: 15];
        pick_wd = req_wdata[12*pick +: 12];
    end

    always_comb begin
        state_n  = state;
        rr_n     = rr_ptr;
        win_n    = win;
        cnt_n    = cnt;
        done_n   = '0;
        err_n    = 1'b0;
        rdata_n  = req_rdata;
        rd_req_n = ram_read_req;
        wr_req_n = ram_write_req;
        ma_n     = ram_ma;
        out_n    = ram_out;
        unique case (state)
            IDLE: begin
                if (found) begin
                    win_n    = pick;
                    ma_n     = pick_ma;
                    out_n    = pick_wd;
                    // Write takes priority when both ops are requested.
                    wr_req_n = pick_wr;
                    rd_req_n = !pick_wr;
                    cnt_n    = '0;
                    state_n  = REQ;
                end
            end
            REQ: begin
                if (ram_done) begin
                    if (ram_read_req) rdata_n = ram_in;
                    rd_req_n = 1'b0;
                    wr_req_n = 1'b0;
                    for (int i = 0; i < NREQ; i++)
                        done_n[i] = (int'(win) == i);
                    state_n = ACK;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th REQ cycle without ram_done.
                    rd_req_n = 1'b0;
                    wr_req_n = 1'b0;
                    err_n    = 1'b1;
                    for (int i = 0; i < NREQ; i++)
                        done_n[i] = (int'(win) == i);
                    state_n = ACK;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ACK: begin
                if (int'(win) == NREQ - 1) rr_n = '0;
                else                       rr_n = win + 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            win           <= '0;
            cnt           <= '0;
            req_done      <= '0;
            req_err       <= 1'b0;
            req_rdata     <= '0;
            ram_read_req  <= 1'b0;
            ram_write_req <= 1'b0;
            ram_ma        <= '0;
            ram_out       <= '0;
        end else begin
            state         <= state_n;
            rr_ptr        <= rr_n;
            win           <= win_n;
            cnt           <= cnt_n;
            req_done      <= done_n;
            req_err       <= err_n;
            req_rdata     <= rdata_n;
            ram_read_req  <= rd_req_n;
            ram_write_req <= wr_req_n;
            ram_ma        <= ma_n;
            ram_out       <= out_n;
        end
    end

endmodule
